// File: rtl/id_pkg.sv
// Shared decode constants for the ARM ID stage.
// Command, mode, condition and opcode encodings plus the control bundle.
package id_pkg;

   localparam logic [3:0] CMD_NOP = 4'b0000;
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;

   localparam logic [1:0] MODE_ALU = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;
   localparam logic [1:0] MODE_NOP = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   typedef struct packed {
      logic       wb;
      logic       mr;
      logic       mw;
      logic       b;
      logic       s;
      logic [3:0] cmd;
   } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// Register file with async reads and same-cycle writeback bypass.
// Reset clears every entry and takes precedence over a write.
module id_regfile
   import id_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int AW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wb_en,
   input  logic [AW-1:0]     i_wb_dest,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic [AW-1:0]     i_ra1,
   input  logic [AW-1:0]     i_ra2,
   output logic [DATA_W-1:0] o_rd1,
   output logic [DATA_W-1:0] o_rd2
);

   logic [DATA_W-1:0] r_mem [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (i_wb_en) begin
         r_mem[i_wb_dest] <= i_wb_data;
      end
   end

   assign o_rd1 = (i_wb_en && i_wb_dest == i_ra1) ? i_wb_data
                                                   : r_mem[i_ra1];
   assign o_rd2 = (i_wb_en && i_wb_dest == i_ra2) ? i_wb_data
                                                   : r_mem[i_ra2];

endmodule

// File: rtl/id_stage_pipe.sv
// ARM decode stage: decode, condition check, operand read and ID/EX register.
// Killed instructions still capture data fields; only controls are zeroed.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREG   = 16,
   parameter int REG_AW = (NREG > 16) ? $clog2(NREG) : 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [31:0]       instr_in,
   input  logic              valid_in,
   input  logic [3:0]        status_in,
   input  logic              hazard,
   input  logic              flush,
   input  logic              freeze,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] src1,
   output logic [REG_AW-1:0] src2,
   output logic              has_src2,
   output logic              ex_valid,
   output logic              ex_wb_en,
   output logic              ex_mem_r_en,
   output logic              ex_mem_w_en,
   output logic              ex_b,
   output logic              ex_s,
   output logic [3:0]        ex_exe_cmd,
   output logic [DATA_W-1:0] ex_pc,
   output logic [DATA_W-1:0] ex_val_rn,
   output logic [DATA_W-1:0] ex_val_rm,
   output logic [REG_AW-1:0] ex_dest,
   output logic [REG_AW-1:0] ex_src1,
   output logic [REG_AW-1:0] ex_src2,
   output logic              ex_imm,
   output logic [11:0]       ex_shift_op,
   output logic [23:0]       ex_imm24
);

   logic [1:0]        w_mode;
   logic [3:0]        w_op;
   logic              w_s;
   logic              w_i;
   logic              w_store;
   logic [REG_AW-1:0] w_rn;
   logic [REG_AW-1:0] w_rd;
   logic [REG_AW-1:0] w_rm;
   logic [REG_AW-1:0] w_src2;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_n, w_z, w_c, w_v;
   logic              w_cond;
   logic              w_kill;
   ctrl_t             w_ctl;
   ctrl_t             w_ctl_g;

   ctrl_t             r_ctl;
   logic              r_valid;
   logic [DATA_W-1:0] r_pc, r_rn, r_rm;
   logic [REG_AW-1:0] r_dest, r_src1, r_src2;
   logic              r_imm;
   logic [11:0]       r_shift;
   logic [23:0]       r_imm24;

   assign w_mode  = instr_in[27:26];
   assign w_i     = instr_in[25];
   assign w_op    = instr_in[24:21];
   assign w_s     = instr_in[20];
   assign w_rn    = REG_AW'(instr_in[19:16]);
   assign w_rd    = REG_AW'(instr_in[15:12]);
   assign w_rm    = REG_AW'(instr_in[3:0]);
   assign w_store = (w_mode == MODE_MEM) & ~w_s;
   assign w_src2  = w_store ? w_rd : w_rm;

   assign src1     = w_rn;
   assign src2     = w_src2;
   assign has_src2 = (~w_i & (w_mode != MODE_MEM)) | w_store;

   always_comb begin
      w_ctl = '0;
      unique case (w_mode)
         MODE_ALU: begin
            w_ctl.s = w_s;
            case (w_op)
               OP_MOV: begin w_ctl.cmd = CMD_MOV; w_ctl.wb = 1'b1; end
               OP_MVN: begin w_ctl.cmd = CMD_MVN; w_ctl.wb = 1'b1; end
               OP_ADD: begin w_ctl.cmd = CMD_ADD; w_ctl.wb = 1'b1; end
               OP_ADC: begin w_ctl.cmd = CMD_ADC; w_ctl.wb = 1'b1; end
               OP_SUB: begin w_ctl.cmd = CMD_SUB; w_ctl.wb = 1'b1; end
               OP_SBC: begin w_ctl.cmd = CMD_SBC; w_ctl.wb = 1'b1; end
               OP_AND: begin w_ctl.cmd = CMD_AND; w_ctl.wb = 1'b1; end
               OP_ORR: begin w_ctl.cmd = CMD_ORR; w_ctl.wb = 1'b1; end
               OP_EOR: begin w_ctl.cmd = CMD_EOR; w_ctl.wb = 1'b1; end
               OP_CMP: w_ctl.cmd = CMD_SUB;
               OP_TST: w_ctl.cmd = CMD_AND;
               default: w_ctl.cmd = CMD_NOP;
            endcase
         end
         MODE_MEM: begin
            w_ctl.cmd = CMD_ADD;
            w_ctl.mr  = w_s;
            w_ctl.wb  = w_s;
            w_ctl.mw  = ~w_s;
         end
         MODE_BR:  w_ctl.b = 1'b1;
         MODE_NOP: w_ctl = '0;
      endcase
   end

   assign {w_n, w_z, w_c, w_v} = status_in;

   always_comb begin
      w_cond = 1'b0;
      unique case (instr_in[31:28])
         COND_EQ: w_cond = w_z;
         COND_NE: w_cond = ~w_z;
         COND_CS: w_cond = w_c;
         COND_CC: w_cond = ~w_c;
         COND_MI: w_cond = w_n;
         COND_PL: w_cond = ~w_n;
         COND_VS: w_cond = w_v;
         COND_VC: w_cond = ~w_v;
         COND_HI: w_cond = w_c & ~w_z;
         COND_LS: w_cond = ~w_c | w_z;
         COND_GE: w_cond = (w_n == w_v);
         COND_LT: w_cond = (w_n != w_v);
         COND_GT: w_cond = ~w_z & (w_n == w_v);
         COND_LE: w_cond = w_z | (w_n != w_v);
         COND_AL: w_cond = 1'b1;
         COND_NV: w_cond = 1'b0;
      endcase
   end

   assign w_kill  = hazard | ~w_cond | ~valid_in;
   assign w_ctl_g = w_kill ? '0 : w_ctl;

   id_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG),
      .AW     (REG_AW)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .i_wb_en   (wb_en),
      .i_wb_dest (wb_dest),
      .i_wb_data (wb_data),
      .i_ra1     (w_rn),
      .i_ra2     (w_src2),
      .o_rd1     (w_rd1),
      .o_rd2     (w_rd2)
   );

   // Flush overrides freeze: it loads the register with controls cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctl   <= '0;
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_rn    <= '0;
         r_rm    <= '0;
         r_dest  <= '0;
         r_src1  <= '0;
         r_src2  <= '0;
         r_imm   <= 1'b0;
         r_shift <= '0;
         r_imm24 <= '0;
      end else if (flush || !freeze) begin
         r_ctl   <= flush ? '0 : w_ctl_g;
         r_valid <= ~flush & ~w_kill;
         r_pc    <= pc_in;
         r_rn    <= w_rd1;
         r_rm    <= w_rd2;
         r_dest  <= w_rd;
         r_src1  <= w_rn;
         r_src2  <= w_src2;
         r_imm   <= w_i;
         r_shift <= instr_in[11:0];
         r_imm24 <= instr_in[23:0];
      end
   end

   assign ex_valid    = r_valid;
   assign ex_wb_en    = r_ctl.wb;
   assign ex_mem_r_en = r_ctl.mr;
   assign ex_mem_w_en = r_ctl.mw;
   assign ex_b        = r_ctl.b;
   assign ex_s        = r_ctl.s;
   assign ex_exe_cmd  = r_ctl.cmd;
   assign ex_pc       = r_pc;
   assign ex_val_rn   = r_rn;
   assign ex_val_rm   = r_rm;
   assign ex_dest     = r_dest;
   assign ex_src1     = r_src1;
   assign ex_src2     = r_src2;
   assign ex_imm      = r_imm;
   assign ex_shift_op = r_shift;
   assign ex_imm24    = r_imm24;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: decode table, directed pipeline sequences,
// condition sweep and randomized run against an instruction-level model.
module tb_id_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic        valid_in;
   logic [3:0]  status_in;
   logic        hazard, flush, freeze;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic [31:0] wb_data;
   logic [3:0]  src1, src2;
   logic        has_src2;
   logic        ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s;
   logic [3:0]  ex_exe_cmd;
   logic [31:0] ex_pc, ex_val_rn, ex_val_rm;
   logic [3:0]  ex_dest, ex_src1, ex_src2;
   logic        ex_imm;
   logic [11:0] ex_shift_op;
   logic [23:0] ex_imm24;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_stage_pipe dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in),
      .valid_in(valid_in), .status_in(status_in), .hazard(hazard),
      .flush(flush), .freeze(freeze), .wb_en(wb_en), .wb_dest(wb_dest),
      .wb_data(wb_data), .src1(src1), .src2(src2), .has_src2(has_src2),
      .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
      .ex_mem_w_en(ex_mem_w_en), .ex_b(ex_b), .ex_s(ex_s),
      .ex_exe_cmd(ex_exe_cmd), .ex_pc(ex_pc), .ex_val_rn(ex_val_rn),
      .ex_val_rm(ex_val_rm), .ex_dest(ex_dest), .ex_src1(ex_src1),
      .ex_src2(ex_src2), .ex_imm(ex_imm), .ex_shift_op(ex_shift_op),
      .ex_imm24(ex_imm24)
   );

   typedef struct packed {
      logic        valid, wb, mr, mw, b, s;
      logic [3:0]  cmd;
      logic [31:0] pc, rn, rm;
      logic [3:0]  dest, src1, src2;
      logic        imm;
      logic [11:0] shift;
      logic [23:0] imm24;
   } ex_t;

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  nzcv;
      logic        valid;
      logic [3:0]  cmd;
      logic        wb, mr, mw, b, s, has2;
      logic [3:0]  src2;
   } vec_t;

   // ALU opcode -> command, and which opcodes write back
   localparam logic [3:0] CMD_TAB [16] = '{
      4'd6, 4'd8, 4'd4, 4'd0, 4'd2, 4'd3, 4'd5, 4'd0,
      4'd6, 4'd0, 4'd4, 4'd0, 4'd7, 4'd1, 4'd0, 4'd9};
   localparam logic [15:0] WB_MASK = 16'hB077;

   ex_t         m_ex;
   logic        m_known;
   logic [31:0] m_rf [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v, base;
      {n, z, cc, v} = f;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cc;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cc & ~z;
         3'd5: base = (n == v);
         3'd6: base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return base ^ c[0];
   endfunction

   function automatic logic [31:0] rd(input logic [3:0] a);
      if (wb_en && wb_dest == a) return wb_data;
      return m_rf[a];
   endfunction

   function automatic logic [3:0] exp_src2();
      if (instr_in[27:26] == 2'b01 && !instr_in[20]) return instr_in[15:12];
      return instr_in[3:0];
   endfunction

   function automatic logic exp_has2();
      logic mem;
      mem = (instr_in[27:26] == 2'b01);
      return (!instr_in[25] && !mem) || (mem && !instr_in[20]);
   endfunction

   function automatic ex_t capture();
      ex_t         e;
      logic [3:0]  op;
      logic [15:0] msk;
      e   = '0;
      op  = instr_in[24:21];
      msk = WB_MASK;
      if (valid_in && !hazard && cond_ok(instr_in[31:28], status_in)) begin
         e.valid = 1'b1;
         case (instr_in[27:26])
            2'b00: begin
               e.cmd = CMD_TAB[op];
               e.wb  = msk[op];
               e.s   = instr_in[20];
            end
            2'b01: begin
               e.cmd = 4'd2;
               e.wb  = instr_in[20];
               e.mr  = instr_in[20];
               e.mw  = !instr_in[20];
            end
            2'b10: e.b = 1'b1;
            default: ;
         endcase
      end
      e.pc    = pc_in;
      e.src1  = instr_in[19:16];
      e.src2  = exp_src2();
      e.rn    = rd(e.src1);
      e.rm    = rd(e.src2);
      e.dest  = instr_in[15:12];
      e.imm   = instr_in[25];
      e.shift = instr_in[11:0];
      e.imm24 = instr_in[23:0];
      return e;
   endfunction

   task automatic tick();
      ex_t nx;
      if (rst) begin
         m_ex    = '0;
         m_known = 1'b1;
      end else if (flush) begin
         nx       = capture();
         m_ex     = nx;
         m_ex.valid = 1'b0;
         m_ex.wb  = 1'b0;
         m_ex.mr  = 1'b0;
         m_ex.mw  = 1'b0;
         m_ex.b   = 1'b0;
         m_ex.s   = 1'b0;
         m_ex.cmd = 4'd0;
         m_known  = 1'b0;
      end else if (!freeze) begin
         m_ex    = capture();
         m_known = 1'b1;
      end
      if (rst) begin
         for (int i = 0; i < 16; i++) m_rf[i] = '0;
      end else if (wb_en) begin
         m_rf[wb_dest] = wb_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_model(input int it);
      string t;
      t = $sformatf("rnd%0d", it);
      chk({t, ".ctl"},
          {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s, ex_exe_cmd},
          {m_ex.valid, m_ex.wb, m_ex.mr, m_ex.mw, m_ex.b, m_ex.s, m_ex.cmd});
      if (m_known) begin
         chk({t, ".pc"}, ex_pc, m_ex.pc);
         chk({t, ".rn"}, ex_val_rn, m_ex.rn);
         chk({t, ".rm"}, ex_val_rm, m_ex.rm);
         chk({t, ".fld"}, {ex_dest, ex_src1, ex_src2, ex_imm},
             {m_ex.dest, m_ex.src1, m_ex.src2, m_ex.imm});
         chk({t, ".imm"}, {ex_shift_op, ex_imm24}, {m_ex.shift, m_ex.imm24});
      end
   endtask

   task automatic wb_write(input logic [3:0] d, input logic [31:0] v);
      valid_in = 1'b0;
      wb_en    = 1'b1;
      wb_dest  = d;
      wb_data  = v;
      tick();
      wb_en    = 1'b0;
   endtask

   function automatic vec_t mkv(input logic [31:0] ins, input logic [3:0] f,
                                input logic v, input logic [3:0] c,
                                input logic w, input logic mr,
                                input logic mw, input logic b,
                                input logic s, input logic h,
                                input logic [3:0] s2);
      vec_t x;
      x.instr = ins; x.nzcv = f; x.valid = v; x.cmd = c;
      x.wb = w; x.mr = mr; x.mw = mw; x.b = b; x.s = s;
      x.has2 = h; x.src2 = s2;
      return x;
   endfunction

   vec_t vt[$];

   initial begin
      vt.push_back(mkv(32'hE0821003, 4'h0, 1, 4'd2, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE2921005, 4'h0, 1, 4'd2, 1, 0, 0, 0, 1, 0, 4'd5));
      vt.push_back(mkv(32'hE1A01003, 4'h0, 1, 4'd1, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE1E01003, 4'h0, 1, 4'd9, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE1520003, 4'h0, 1, 4'd4, 0, 0, 0, 0, 1, 1, 4'd3));
      vt.push_back(mkv(32'hE1120003, 4'h0, 1, 4'd6, 0, 0, 0, 0, 1, 1, 4'd3));
      vt.push_back(mkv(32'hE0621003, 4'h0, 1, 4'd0, 0, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE0221003, 4'h0, 1, 4'd8, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE0A21003, 4'h0, 1, 4'd3, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE0C21003, 4'h0, 1, 4'd5, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE0421003, 4'h0, 1, 4'd4, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE0021003, 4'h0, 1, 4'd6, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE1821003, 4'h0, 1, 4'd7, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'hE5954000, 4'h0, 1, 4'd2, 1, 1, 0, 0, 0, 0, 4'd0));
      vt.push_back(mkv(32'hE5854000, 4'h0, 1, 4'd2, 0, 0, 1, 0, 0, 1, 4'd4));
      vt.push_back(mkv(32'hEA000010, 4'h0, 1, 4'd0, 0, 0, 0, 1, 0, 0, 4'd0));
      vt.push_back(mkv(32'hEF000000, 4'h0, 1, 4'd0, 0, 0, 0, 0, 0, 0, 4'd0));
      vt.push_back(mkv(32'h00821003, 4'h0, 0, 4'd0, 0, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'h00821003, 4'h4, 1, 4'd2, 1, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'h11821003, 4'h4, 0, 4'd0, 0, 0, 0, 0, 0, 1, 4'd3));
      vt.push_back(mkv(32'h11821003, 4'h0, 1, 4'd7, 1, 0, 0, 0, 0, 1, 4'd3));

      rst = 1'b1; pc_in = 32'h100; instr_in = '0; valid_in = 1'b0;
      status_in = '0; hazard = 1'b0; flush = 1'b0; freeze = 1'b0;
      wb_en = 1'b0; wb_dest = '0; wb_data = '0;
      m_ex = '0; m_known = 1'b0;
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      @(negedge clk);
      tick();
      rst = 1'b0;
      chk("rst.ctl", {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b,
                      ex_s, ex_exe_cmd}, '0);
      chk("rst.pc", ex_pc, 32'h0);
      chk("rst.vals", ex_val_rn | ex_val_rm, 32'h0);
      chk("rst.flds", {ex_dest, ex_src1, ex_src2, ex_imm, ex_shift_op,
                       ex_imm24}, '0);

      for (int r = 0; r < 16; r++)
         wb_write(4'(r), (r == 2) ? 32'd5 : (r == 3) ? 32'd7 : 32'h100 + r);

      // ADD R1,R2,R3
      instr_in = 32'hE0821003; valid_in = 1'b1; pc_in = 32'h104;
      #1;
      chk("add.src1", 32'(src1), 32'd2);
      chk("add.src2", 32'(src2), 32'd3);
      chk("add.has2", 32'(has_src2), 32'd1);
      tick();
      chk("add.cmd", 32'(ex_exe_cmd), 32'd2);
      chk("add.wb", 32'(ex_wb_en), 32'd1);
      chk("add.rn", ex_val_rn, 32'd5);
      chk("add.rm", ex_val_rm, 32'd7);
      chk("add.dest", 32'(ex_dest), 32'd1);
      chk("add.valid", 32'(ex_valid), 32'd1);
      chk("add.pc", ex_pc, 32'h104);

      // writeback bypass into the same cycle's read
      wb_en = 1'b1; wb_dest = 4'd2; wb_data = 32'hAA;
      tick();
      wb_en = 1'b0;
      chk("byp.rn", ex_val_rn, 32'hAA);
      chk("byp.rm", ex_val_rm, 32'd7);
      tick();
      chk("byp.persist", ex_val_rn, 32'hAA);
      wb_write(4'd2, 32'd5);

      foreach (vt[k]) begin
         string t;
         t = $sformatf("vec%0d", k);
         instr_in = vt[k].instr; status_in = vt[k].nzcv;
         valid_in = 1'b1; hazard = 1'b0;
         #1;
         chk({t, ".has2"}, 32'(has_src2), 32'(vt[k].has2));
         chk({t, ".src2"}, 32'(src2), 32'(vt[k].src2));
         tick();
         chk({t, ".valid"}, 32'(ex_valid), 32'(vt[k].valid));
         chk({t, ".cmd"}, 32'(ex_exe_cmd), 32'(vt[k].cmd));
         chk({t, ".ctl"}, {ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s},
             {vt[k].wb, vt[k].mr, vt[k].mw, vt[k].b, vt[k].s});
      end

      // STR R4,[R5]: store data register read via src2
      instr_in = 32'hE5854000; status_in = 4'h0; valid_in = 1'b1;
      tick();
      chk("str.rm", ex_val_rm, 32'h104);
      chk("str.rn", ex_val_rn, 32'h105);
      hazard = 1'b1;
      tick();
      hazard = 1'b0;
      chk("str.bubble", {ex_valid, ex_wb_en, ex_mem_w_en, ex_exe_cmd}, '0);

      // freeze holds, flush during freeze clears controls
      instr_in = 32'hE0821003; pc_in = 32'h200;
      tick();
      freeze = 1'b1;
      for (int k = 0; k < 3; k++) begin
         instr_in = (k == 0) ? 32'hE1A01003 : (k == 1) ? 32'hEA000010
                                                       : 32'hE5854000;
         pc_in = 32'h300 + k * 4;
         tick();
         chk($sformatf("frz%0d.ctl", k),
             {ex_valid, ex_wb_en, ex_mem_w_en, ex_b, ex_exe_cmd},
             {1'b1, 1'b1, 1'b0, 1'b0, 4'd2});
         chk($sformatf("frz%0d.pc", k), ex_pc, 32'h200);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0; freeze = 1'b0;
      chk("frz.flush", {ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b,
                        ex_s, ex_exe_cmd}, '0);

      // reset beats a simultaneous writeback
      instr_in = 32'hE0821003; rst = 1'b1;
      wb_en = 1'b1; wb_dest = 4'd3; wb_data = 32'h123;
      tick();
      rst = 1'b0; wb_en = 1'b0;
      chk("rst2.ctl", {ex_valid, ex_wb_en, ex_exe_cmd}, '0);
      chk("rst2.data", {ex_pc, ex_val_rn, ex_val_rm, ex_dest}, '0);
      for (int a = 0; a < 16; a++) begin
         instr_in = 32'hE0801000 | (32'(a) << 16) | 32'(15 - a);
         tick();
         chk($sformatf("rst2.r%0d", a), ex_val_rn | ex_val_rm, 32'h0);
      end

      // every condition against every flag combination
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            instr_in = {4'(c), 28'h0821003}; status_in = 4'(f);
            tick();
            chk($sformatf("cond%0d_%0d", c, f), {ex_valid, ex_wb_en},
                {2{cond_ok(4'(c), 4'(f))}});
         end
      end

      for (int it = 0; it < 600; it++) begin
         instr_in  = $urandom;
         pc_in     = $urandom;
         status_in = 4'($urandom);
         valid_in  = ($urandom_range(7) != 0);
         hazard    = ($urandom_range(7) == 0);
         flush     = ($urandom_range(15) == 0);
         freeze    = ($urandom_range(7) == 0);
         rst       = ($urandom_range(63) == 0);
         wb_en     = $urandom_range(1);
         wb_dest   = 4'($urandom);
         wb_data   = $urandom;
         if ($urandom_range(1) == 1) instr_in[31:28] = 4'hE;
         #1;
         chk($sformatf("rnd%0d.comb", it), {src1, src2, has_src2},
             {instr_in[19:16], exp_src2(), exp_has2()});
         tick();
         cmp_model(it);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised decode stage for the ARM pipeline. It decodes the instruction, evaluates its condition code, reads operands from an embedded register file that forwards same-cycle writeback data, and captures everything in an integrated ID/EX pipeline register. The register supports bubble insertion on hazard, flush on taken branch, and a freeze that holds its contents. It sits between the IF/ID register and the EXE stage, and feeds the hazard unit combinationally.

## Interface
- DATA_W, 32, datapath and register width
- NREG, 16, architectural registers; REG_AW = $clog2(NREG), minimum 4
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- pc_in  in  DATA_W  PC+4 of the instruction in ID
- instr_in  in  32  instruction word
- valid_in  in  1  instr_in is a real instruction
- status_in  in  4  {N,Z,C,V} from the status register
- hazard  in  1  insert bubble (from hazard unit)
- flush  in  1  branch taken in EXE; kill the ID instruction
- freeze  in  1  hold the ID/EX register unchanged
- wb_en / wb_dest / wb_data  in  1 / REG_AW / DATA_W  writeback port
- src1, src2  out  REG_AW  combinational read addresses for the hazard unit
- has_src2  out  1  combinational: (~I & ~mem) | store
- ex_valid, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_b, ex_s  out  1 each  registered controls
- ex_exe_cmd  out  4  registered ALU command
- ex_pc, ex_val_rn, ex_val_rm  out  DATA_W  registered
- ex_dest  out  REG_AW  instr[15:12]
- ex_src1, ex_src2  out  REG_AW  registered, for forwarding
- ex_imm  out  1  instr[25]
- ex_shift_op  out  12  instr[11:0]
- ex_imm24  out  24  instr[23:0]

## Operation
- Field mapping: mode = instr[27:26]; opcode = instr[24:21]; S = instr[20]; Rn = instr[19:16]; Rd = instr[15:12]; Rm = instr[3:0]. src1 = Rn. src2 = Rd for stores, otherwise Rm. Register fields wider than REG_AW are truncated to the LSBs.
- Decode for mode 00 (exe_cmd, wb):
  - MOV 1101 → 0001, wb
  - MVN 1111 → 1001, wb
  - ADD 0100 → 0010, wb
  - ADC 0101 → 0011, wb
  - SUB 0010 → 0100, wb
  - SBC 0110 → 0101, wb
  - AND 0000 → 0110, wb
  - ORR 1100 → 0111, wb
  - EOR 0001 → 1000, wb
  - CMP 1010 → 0100, no wb
  - TST 1000 → 0110, no wb
  - Any other opcode → 0000, no wb
- Decode for other modes:
  - Mode 01, S=1 (LDR): cmd 0010, mem_r, wb.
  - Mode 01, S=0 (STR): cmd 0010, mem_w.
  - Mode 10: B=1.
  - Mode 11: NOP (all zero).
- S output: S for mode 00; 0 for mode 01 and mode 10.
- Condition on instr[31:28]:
  - EQ Z; NE ~Z; CS C; CC ~C
  - MI N; PL ~N; VS V; VC ~V
  - HI C&~Z; LS ~C|Z
  - GE N==V; LT N!=V
  - GT ~Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 = never
- kill = hazard | ~cond | ~valid_in. When kill is set, every registered control bit, ex_valid and ex_exe_cmd are zero. Data fields are still captured.
- Register file: write on the rising edge when wb_en. Reads are asynchronous. If wb_en and wb_dest equals a read address, that read returns wb_data (write-through).

## Timing
- Next-state priority at each edge: rst > flush > freeze > normal capture.
  - rst: every ex_* output 0 and every register-file entry 0.
  - flush: all controls and ex_valid 0. Flush overrides freeze.
  - freeze: all ex_* hold their values. Register-file writes still occur.
  - normal: capture decode gated by kill.
- Latency: one cycle from instr_in to ex_*.
- src1, src2 and has_src2 are purely combinational from instr_in.
- A writeback in cycle t is visible on ex_val_* at t+1 through the bypass.
- Reset asserted mid-stream zeroes the ID/EX register at that edge. It also zeroes the register file, even when wb_en is asserted in the same cycle (reset wins).

## Structure
- Shared package id_pkg holds:
  - exe_cmd localparams: CMD_MOV, CMD_ADD, ...
  - mode encodings
  - condition encodings
  - the opcode constants
- Sub-module id_regfile, parametrised by DATA_W and NREG, implements the bypassed register file.
- Decode and condition logic are combinational blocks in the top level; the ID/EX register is a single always block.

## Test plan
- ADD R1,R2,R3 (0xE0821003), R2=5, R3=7 → after 1 clk: ex_exe_cmd=0010, ex_wb_en=1, ex_val_rn=5, ex_val_rm=7, ex_dest=1, ex_valid=1.
- Same cycle: wb_en=1, wb_dest=2, wb_data=0xAA, with instr reading R2 → ex_val_rn=0xAA.
- ADDEQ with Z=0 → ex_valid=0 and all controls 0. With Z=1 → ex_wb_en=1. Sweep all 16 conditions against every NZCV combination.
- STR R4,[R5] → src2=4, has_src2=1, ex_mem_w_en=1, ex_wb_en=0. hazard=1 on the same instruction → bubble.
- freeze=1 for 3 clk with changing instr_in → ex_* held. Assert flush during freeze → controls cleared next edge.
- rst for 1 clk with wb_en=1 → all ex_* 0. Subsequent read of any register returns 0.
